// File: rtl/apb_reg_bank.sv
// APB3 register bank (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE) feeding the ECC core, with a CTRL-write start pulse.
// Optional macro APB_PSLVERR_EN: adds PSLVERR and rejects accesses with nonzero PADDR[AMBA_ADDR_WIDTH-1:4].
module apb_reg_bank #(
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned AMBA_ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic [AMBA_WORD-1:0]       CTRL,
    output logic [AMBA_WORD-1:0]       DATA_IN,
    output logic [AMBA_WORD-1:0]       CODEWORD_WIDTH,
    output logic [AMBA_WORD-1:0]       NOISE,
`ifdef APB_PSLVERR_EN
    output logic                       PSLVERR,
`endif
    output logic                       start
);

    localparam logic [1:0] SEL_CTRL  = 2'd0;
    localparam logic [1:0] SEL_DATA  = 2'd1;
    localparam logic [1:0] SEL_CWW   = 2'd2;
    localparam logic [1:0] SEL_NOISE = 2'd3;

    // Keeps only the core data bits of DATA_IN / NOISE writes.
    localparam logic [AMBA_WORD-1:0] DATA_MASK =
        (DATA_WIDTH >= AMBA_WORD) ? {AMBA_WORD{1'b1}}
                                  : AMBA_WORD'((64'(1) << DATA_WIDTH) - 64'(1));

    logic             addr_ok;
    logic             wr_en;
    logic [1:0]       sel;
    logic [AMBA_WORD-1:0] rd_word;
    logic             unused_addr;

    assign sel = PADDR[3:2];

`ifdef APB_PSLVERR_EN
    assign addr_ok     = (PADDR[AMBA_ADDR_WIDTH-1:4] == '0);
    assign PSLVERR     = PSEL & PENABLE & ~addr_ok;
    assign unused_addr = ^PADDR[1:0];
`else
    // Upper address bits are don't-care, so registers alias every 16 bytes.
    assign addr_ok     = 1'b1;
    assign unused_addr = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]};
`endif

    assign wr_en = PSEL & PENABLE & PWRITE & addr_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            CTRL           <= '0;
            DATA_IN        <= '0;
            CODEWORD_WIDTH <= '0;
            NOISE          <= '0;
            start          <= 1'b0;
        end else begin
            start <= wr_en && (sel == SEL_CTRL);
            if (wr_en) begin
                case (sel)
                    SEL_CTRL:  CTRL           <= PWDATA;
                    SEL_DATA:  DATA_IN        <= PWDATA & DATA_MASK;
                    SEL_CWW:   CODEWORD_WIDTH <= PWDATA;
                    SEL_NOISE: NOISE          <= PWDATA & DATA_MASK;
                    default:   ;
                endcase
            end
        end
    end

    // Read path is combinational and valid in both setup and access phases.
    always_comb begin
        rd_word = '0;
        case (sel)
            SEL_CTRL:  rd_word = CTRL;
            SEL_DATA:  rd_word = DATA_IN;
            SEL_CWW:   rd_word = CODEWORD_WIDTH;
            SEL_NOISE: rd_word = NOISE;
            default:   rd_word = '0;
        endcase
    end

    assign PRDATA = (PSEL && !PWRITE && addr_ok) ? rd_word : '0;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank (DATA_WIDTH=8 instance so masking is exercised on every run).
module tb_apb_reg_bank;

    logic        clk;
    logic        rst;
    logic [19:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic [31:0] CTRL;
    logic [31:0] DATA_IN;
    logic [31:0] CODEWORD_WIDTH;
    logic [31:0] NOISE;
    logic        start;
`ifdef APB_PSLVERR_EN
    logic        PSLVERR;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    apb_reg_bank #(
        .AMBA_WORD      (32),
        .AMBA_ADDR_WIDTH(20),
        .DATA_WIDTH     (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PADDR         (PADDR),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PWDATA        (PWDATA),
        .PRDATA        (PRDATA),
        .CTRL          (CTRL),
        .DATA_IN       (DATA_IN),
        .CODEWORD_WIDTH(CODEWORD_WIDTH),
        .NOISE         (NOISE),
`ifdef APB_PSLVERR_EN
        .PSLVERR       (PSLVERR),
`endif
        .start         (start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Called at posedge+1; returns at posedge+1 after the access edge.
    task automatic apb_write(input logic [19:0] addr, input logic [31:0] data);
        logic       mapped;
        logic [1:0] a32;
`ifdef APB_PSLVERR_EN
        mapped = (addr[19:4] == 16'h0);
`else
        mapped = 1'b1;
`endif
        a32 = addr[3:2];
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(posedge clk); #1;
        check("start_setup", {31'b0, start}, 32'h0);
        PENABLE = 1'b1;
        #1;
`ifdef APB_PSLVERR_EN
        check("pslverr", {31'b0, PSLVERR}, {31'b0, ~mapped});
`endif
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        check("start_pulse", {31'b0, start}, {31'b0, mapped && (a32 == 2'd0)});
    endtask

    task automatic apb_read(input logic [19:0] addr, input logic [31:0] exp);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        #1;
        check("rd_setup", PRDATA, exp);
        @(posedge clk); #1;
        PENABLE = 1'b1;
        #1;
        check("rd_access", PRDATA, exp);
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        check("rd_no_start", {31'b0, start}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
        #1;
        check("rst_ctrl", CTRL, 32'h0);
        check("rst_start", {31'b0, start}, 32'h0);
        check("rst_prdata", PRDATA, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // CTRL write via an address with byte offset bits set
        apb_write(20'h00001, 32'h5);
        check("ctrl_5", CTRL, 32'h5);
        check("data_in_unchanged", DATA_IN, 32'h0);
        @(posedge clk); #1;
        check("start_one_cycle", {31'b0, start}, 32'h0);

        apb_write(20'h00000, 32'h0A);
        apb_write(20'h00004, 32'h0B);
        apb_write(20'h00008, 32'h0C);
        apb_write(20'h0000C, 32'h0D);
        check("ctrl_a", CTRL, 32'h0A);
        check("data_in_b", DATA_IN, 32'h0B);
        check("cww_c", CODEWORD_WIDTH, 32'h0C);
        check("noise_d", NOISE, 32'h0D);
        apb_read(20'h00000, 32'h0A);
        apb_read(20'h00004, 32'h0B);
        apb_read(20'h00008, 32'h0C);
        apb_read(20'h0000C, 32'h0D);
`ifdef APB_PSLVERR_EN
        apb_read(20'h00020, 32'h0);
`else
        apb_read(20'h00020, 32'h0A);
`endif

        // Setup phase held for three cycles: nothing may change
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h0; PWDATA = 32'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("setup_only_start", {31'b0, start}, 32'h0);
        end
        PSEL = 1'b0; PWRITE = 1'b0;
        check("setup_only_ctrl", CTRL, 32'h0A);

        // PENABLE without PSEL is ignored
        PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 20'h0; PWDATA = 32'h33;
        @(posedge clk); #1;
        PENABLE = 1'b0; PWRITE = 1'b0;
        check("nosel_ctrl", CTRL, 32'h0A);
        check("nosel_start", {31'b0, start}, 32'h0);

        // Masking to 8 data bits on DATA_IN/NOISE only
        apb_write(20'h00004, 32'h1FF);
        check("mask_data_in", DATA_IN, 32'hFF);
        apb_read(20'h00004, 32'hFF);
        apb_write(20'h0000C, 32'hABCD);
        check("mask_noise", NOISE, 32'hCD);
        apb_write(20'h00008, 32'h1FF);
        check("cww_unmasked", CODEWORD_WIDTH, 32'h1FF);
        apb_write(20'h00000, 32'hDEADBEEF);
        check("ctrl_unmasked", CTRL, 32'hDEADBEEF);

        // Zero write still pulses; back-to-back writes give separate pulses
        apb_write(20'h00000, 32'h0);
        check("ctrl_zero", CTRL, 32'h0);
        apb_write(20'h00000, 32'h1);
        apb_write(20'h00000, 32'h2);
        check("ctrl_b2b", CTRL, 32'h2);

`ifdef APB_PSLVERR_EN
        apb_write(20'h00010, 32'h77);
        check("unmapped_ctrl", CTRL, 32'h2);
        apb_write(20'h00000, 32'h3);
        check("mapped_ctrl", CTRL, 32'h3);
`endif

        // Asynchronous reset while start is high and a read is in progress
        apb_write(20'h00000, 32'h99);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = 20'h4;
        #2;
        rst = 1'b0;
        #1;
        check("arst_ctrl", CTRL, 32'h0);
        check("arst_data_in", DATA_IN, 32'h0);
        check("arst_cww", CODEWORD_WIDTH, 32'h0);
        check("arst_noise", NOISE, 32'h0);
        check("arst_start", {31'b0, start}, 32'h0);
        check("arst_prdata", PRDATA, 32'h0);
        PSEL = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        apb_write(20'h00000, 32'h7);
        check("post_rst_ctrl", CTRL, 32'h7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_reg_bank.md
Name: apb_reg_bank

Overview:
- APB3-style slave (no wait states) holding the four configuration registers of the ECC encode/decode datapath: CTRL, DATA_IN, CODEWORD_WIDTH and NOISE.
- Register contents drive the core continuously through dedicated outputs.
- A one-cycle start pulse follows every write to CTRL, so the core launches an operation.
- Sits between the system APB interconnect and the ECC core.

Parameters:
AMBA_WORD, 32, APB data width and width of every register/output word
AMBA_ADDR_WIDTH, 20, PADDR width
DATA_WIDTH, 32, ECC core data width; DATA_IN and NOISE writes keep only bits [DATA_WIDTH-1:0], upper bits read 0 (must be <= AMBA_WORD)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
PADDR  in  AMBA_ADDR_WIDTH  APB address
PSEL  in  1  slave select
PENABLE  in  1  access phase indicator
PWRITE  in  1  1=write, 0=read
PWDATA  in  AMBA_WORD  write data
PRDATA  out  AMBA_WORD  read data
CTRL  out  AMBA_WORD  control register contents
DATA_IN  out  AMBA_WORD  data word register contents
CODEWORD_WIDTH  out  AMBA_WORD  codeword width register contents
NOISE  out  AMBA_WORD  noise vector register contents
start  out  1  one-cycle operation launch pulse

Behaviour:
- Reset: when rst=0, asynchronously clear CTRL, DATA_IN, CODEWORD_WIDTH, NOISE and start to 0. PRDATA reads 0 while not in a read access.
- Address decode uses PADDR[3:2]:
  - 0 = CTRL
  - 1 = DATA_IN
  - 2 = CODEWORD_WIDTH
  - 3 = NOISE
  - PADDR[1:0] are ignored. Without the optional feature, bits above 3 are ignored, so addresses alias.
- Protocol: setup phase (PSEL=1, PENABLE=0) has no effect. The access phase is PSEL=1 and PENABLE=1. PREADY is implicitly 1, so every access completes in its access cycle.
- Write: on the rising edge with PSEL & PENABLE & PWRITE, the addressed register takes PWDATA.
  - DATA_IN and NOISE are masked to DATA_WIDTH bits.
  - Other registers are unchanged.
  - Only one write per access, since only one access cycle exists.
- Read: PRDATA is combinational. It equals the addressed register when PSEL=1 and PWRITE=0 (setup and access phases), otherwise 0. Reads have no side effects.
- start:
  - Registered. It is 1 in exactly the clock cycle after the edge on which CTRL was written, otherwise 0.
  - Writing 0 to CTRL still pulses start.
  - Back-to-back CTRL writes (minimum 2 cycles apart) give separate single pulses.
- Outputs CTRL/DATA_IN/CODEWORD_WIDTH/NOISE are direct register outputs. A new value is visible the cycle after the write edge.
- PENABLE=1 with PSEL=0: ignored.
- Reset mid-transfer: the transfer is aborted, all registers clear immediately, and start drops.

Optional Feature:
- Macro APB_PSLVERR_EN.
- Defined:
  - Adds output PSLVERR (1 bit). It equals 1 during an access phase (PSEL & PENABLE) when PADDR[AMBA_ADDR_WIDTH-1:4] != 0, otherwise 0.
  - Such accesses are unmapped: writes are discarded (no register change, no start) and PRDATA=0.
- Undefined: no PSLVERR port; upper address bits are ignored and addresses alias.

Test Plan:
- Reset: drive rst=0 mid-run after registers are loaded -> all four outputs, start and PRDATA read 0 immediately, without a clock edge.
- Write CTRL: PADDR=0x1, PWDATA=0x5, setup then access -> CTRL=0x5 after the access edge; start=1 for exactly one cycle after it; DATA_IN unchanged.
- Write all: write 0x0A/0x0B/0x0C/0x0D to 0x0/0x4/0x8/0xC, then read each back -> PRDATA equals the written value during the access phase; start pulses only after the CTRL write.
- Setup-only: PSEL=1, PENABLE=0, PWRITE=1 for 3 cycles, then deassert -> no register changes, start stays 0.
- Masking: DATA_WIDTH=8, write 0x1FF to DATA_IN -> DATA_IN=0xFF and reads 0xFF.
- Feature: with APB_PSLVERR_EN, write to 0x10 -> PSLVERR=1 in the access cycle, CTRL unchanged, no start; write to 0x0 -> PSLVERR=0.
